// File: rtl/dff_bist_ctrl_if.sv
// Signal bundle between the BIST controller, its start/status client and the flip-flop under test.
interface dff_bist_ctrl_if #(
  parameter int unsigned ERR_W = 16
);
  logic             start;
  logic             dut_q;
  logic             dut_d;
  logic             dut_reset;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      vec_count;

  modport master (
    input  start, dut_q,
    output dut_d, dut_reset, busy, done, pass, err_count, vec_count
  );

  modport slave (
    output start, dut_q,
    input  dut_d, dut_reset, busy, done, pass, err_count, vec_count
  );
endinterface

// File: rtl/dff_bist_ctrl.sv
// BIST controller for a single-bit D flip-flop with synchronous reset: resets it, streams an
// 8-bit LFSR pattern into d and checks every q against a one-cycle-delayed model.
module dff_bist_ctrl #(
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int unsigned NUM_VECTORS = 200,
  parameter int unsigned ERR_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  dff_bist_ctrl_if.master bus
);

  localparam int unsigned VEC_W    = 16;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       lfsr, lfsr_nxt;
  logic             exp_q, exp_q_nxt;
  logic             rst_cnt, rst_cnt_nxt;
  logic             dut_d, dut_d_nxt;
  logic             dut_reset, dut_reset_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             pass, pass_nxt;
  logic [ERR_W-1:0] err_count, err_count_nxt;
  logic [VEC_W-1:0] vec_count, vec_count_nxt;
  logic             compare;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    exp_q_nxt     = exp_q;
    rst_cnt_nxt   = 1'b0;
    dut_d_nxt     = 1'b0;
    err_count_nxt = err_count;
    vec_count_nxt = vec_count;
    compare       = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt     = S_DUT_RST;
          err_count_nxt = '0;
          vec_count_nxt = '0;
          lfsr_nxt      = SEED;
        end
      end
      S_DUT_RST: begin
        exp_q_nxt = 1'b0;
        if (rst_cnt) begin
          state_nxt = S_RUN;
          dut_d_nxt = lfsr[7];
          lfsr_nxt  = lfsr_step(lfsr);
        end else begin
          rst_cnt_nxt = 1'b1;
        end
      end
      S_RUN: begin
        compare       = 1'b1;
        exp_q_nxt     = dut_d;
        vec_count_nxt = vec_count + VEC_W'(1);
        if (vec_count == LAST_VEC) begin
          state_nxt = S_DRAIN;
        end else begin
          dut_d_nxt = lfsr[7];
          lfsr_nxt  = lfsr_step(lfsr);
        end
      end
      S_DRAIN: begin
        compare   = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Saturating mismatch counter.
    if (compare && (bus.dut_q != exp_q) && (err_count != ERR_MAX)) begin
      err_count_nxt = err_count + ERR_W'(1);
    end

    dut_reset_nxt = !((state_nxt == S_RUN) || (state_nxt == S_DRAIN));
    busy_nxt      = (state_nxt == S_DUT_RST) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
    done_nxt      = (state_nxt == S_DONE);
    pass_nxt      = done_nxt && (err_count_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      exp_q     <= 1'b0;
      rst_cnt   <= 1'b0;
      dut_d     <= 1'b0;
      dut_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      exp_q     <= exp_q_nxt;
      rst_cnt   <= rst_cnt_nxt;
      dut_d     <= dut_d_nxt;
      dut_reset <= dut_reset_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_count_nxt;
      vec_count <= vec_count_nxt;
    end
  end

  assign bus.dut_d     = dut_d;
  assign bus.dut_reset = dut_reset;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.vec_count = vec_count;

endmodule

// File: tb/tb_dff_bist_ctrl.sv
// Bench for dff_bist_ctrl: two configurations driving a flip-flop that can be correct,
// stuck at 1, a plain wire, or randomly corrupted; results checked against a pattern model.
module tb_dff_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_v;
  int   sel;
  int   mode;
  int   checks;
  int   errors;

  dff_bist_ctrl_if #(.ERR_W(16)) ia ();
  dff_bist_ctrl_if #(.ERR_W(4))  ib ();

  dff_bist_ctrl #(.SEED(8'hA5), .NUM_VECTORS(200), .ERR_W(16)) ua (
    .clk(clk), .reset(reset), .bus(ia.master)
  );
  dff_bist_ctrl #(.SEED(8'h01), .NUM_VECTORS(60), .ERR_W(4)) ub (
    .clk(clk), .reset(reset), .bus(ib.master)
  );

  // Flip-flops under test plus fault injection: 0 good, 1 stuck-at-1, 2 wire, 3 random flips.
  logic ffa, ffb, flip;
  always @(posedge clk) begin
    ffa  <= ia.dut_reset ? 1'b0 : ia.dut_d;
    ffb  <= ib.dut_reset ? 1'b0 : ib.dut_d;
    flip <= ($urandom_range(0, 5) == 0);
  end

  function automatic logic fault_q(input int m, input logic ff, input logic d, input logic f);
    case (m)
      1:       return 1'b1;
      2:       return d;
      3:       return ff ^ f;
      default: return ff;
    endcase
  endfunction

  assign ia.start = start_v && (sel == 0);
  assign ib.start = start_v && (sel == 1);
  assign ia.dut_q = fault_q(mode, ffa, ia.dut_d, flip);
  assign ib.dut_q = fault_q(mode, ffb, ib.dut_d, flip);

  logic        o_d, o_rst, o_busy, o_done, o_pass, o_q;
  logic [15:0] o_err, o_vec;
  assign o_d    = (sel == 0) ? ia.dut_d     : ib.dut_d;
  assign o_rst  = (sel == 0) ? ia.dut_reset : ib.dut_reset;
  assign o_busy = (sel == 0) ? ia.busy      : ib.busy;
  assign o_done = (sel == 0) ? ia.done      : ib.done;
  assign o_pass = (sel == 0) ? ia.pass      : ib.pass;
  assign o_q    = (sel == 0) ? ia.dut_q     : ib.dut_q;
  assign o_err  = (sel == 0) ? ia.err_count : 16'(ib.err_count);
  assign o_vec  = (sel == 0) ? ia.vec_count : ib.vec_count;

  logic bits  [0:255];
  logic qseen [0:256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pattern model: d bit k is the MSB of the k-th LFSR state starting from the seed.
  task automatic gen_bits(input int seed, input int n);
    int s;
    int fb;
    s = seed;
    for (int k = 0; k < n; k++) begin
      bits[k] = 1'((s >> 7) & 1);
      fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
      s = ((s << 1) | fb) & 255;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_pass"}, 32'(o_pass), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_vec"}, 32'(o_vec), 32'd0);
    chk({tag, "_dut_reset"}, 32'(o_rst), 32'd1);
    chk({tag, "_dut_d"}, 32'(o_d), 32'd0);
  endtask

  // One complete run on instance inst with flip-flop mode m; optional stray start pulses in RUN.
  task automatic run(input int inst, input int m, input bit poke);
    int n, errmax, cnt, exp_err;
    logic expq;
    n      = (inst == 0) ? 200 : 60;
    errmax = (inst == 0) ? 65535 : 15;
    gen_bits((inst == 0) ? 'hA5 : 'h01, n);
    sel  = inst;
    mode = m;
    @(negedge clk) start_v = 1'b1;
    @(negedge clk) start_v = 1'b0;
    chk("rst1_busy", 32'(o_busy), 32'd1);
    chk("rst1_dut_reset", 32'(o_rst), 32'd1);
    chk("rst1_err_clr", 32'(o_err), 32'd0);
    chk("rst1_vec_clr", 32'(o_vec), 32'd0);
    chk("rst1_done_clr", 32'(o_done), 32'd0);
    @(negedge clk);
    chk("rst2_dut_reset", 32'(o_rst), 32'd1);
    chk("rst2_dut_d", 32'(o_d), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("run_dut_d", 32'(o_d), 32'(bits[k]));
      if (k == 0) chk("run_dut_reset", 32'(o_rst), 32'd0);
      if (inst == 1 && k < 8) chk("seed01_first8", 32'(o_d), (k == 7) ? 32'd1 : 32'd0);
      qseen[k] = o_q;
      start_v = poke && (k < n - 3) && ($urandom_range(0, 3) == 0);
    end
    start_v = 1'b0;
    @(negedge clk);
    qseen[n] = o_q;
    chk("drain_busy", 32'(o_busy), 32'd1);
    chk("drain_done", 32'(o_done), 32'd0);
    @(negedge clk);
    cnt = 0;
    for (int j = 0; j <= n; j++) begin
      expq = (j == 0) ? 1'b0 : bits[j-1];
      if (qseen[j] !== expq) cnt++;
    end
    exp_err = (cnt > errmax) ? errmax : cnt;
    chk("done_flag", 32'(o_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd0);
    chk("done_err", 32'(o_err), 32'(exp_err));
    chk("done_vec", 32'(o_vec), 32'(n));
    chk("done_pass", 32'(o_pass), (exp_err == 0) ? 32'd1 : 32'd0);
    chk("done_dut_reset", 32'(o_rst), 32'd1);
    if (m == 0) chk("good_ff_pass", 32'(o_pass), 32'd1);
    if (m == 2) chk("wire_err_nz", 32'(o_err != 16'd0), 32'd1);
    @(negedge clk);
    chk("done_hold", 32'(o_done), 32'd1);
    chk("vec_hold", 32'(o_vec), 32'(n));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start_v = 1'b0;
    sel     = 0;
    mode    = 0;
    repeat (3) @(negedge clk);
    check_idle("reset_a");
    sel = 1;
    #1;
    check_idle("reset_b");
    reset = 1'b0;
    sel   = 0;

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 0, 1'b0);
    run(0, 3, 1'b0);

    // Abort in the middle of RUN with a stuck flip-flop so counters are nonzero first.
    sel  = 0;
    mode = 1;
    @(negedge clk) start_v = 1'b1;
    @(negedge clk) start_v = 1'b0;
    repeat (52) @(negedge clk);
    chk("pre_abort_busy", 32'(o_busy), 32'd1);
    chk("pre_abort_err_nz", 32'(o_err != 16'd0), 32'd1);
    chk("pre_abort_vec", 32'(o_vec), 32'd50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("abort");
    @(negedge clk);
    check_idle("abort_hold");

    run(0, 0, 1'b0);
    run(1, 0, 1'b0);
    run(1, 1, 1'b1);
    run(1, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
